// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sequencer
// Description : Operand sequencer and result collector for a 1-bit serial
//               adder. Streams two W-bit operands LSB-first, collects the
//               sum bit stream into a parallel result, and runs one flush
//               cycle per word so the adder's carry register ends clear.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_sequencer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         ser_a,
    output logic         ser_b,
    input  logic         ser_sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);

    localparam int               CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     shift_a_q, shift_a_d;
    logic [W-1:0]     shift_b_q, shift_b_d;
    logic [W-1:0]     sum_sh_q, sum_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cout_q, cout_d;

    // State and datapath registers; async active-low reset aborts any word in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_sh_q  <= '0;
            cnt_q     <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_sh_q  <= sum_sh_d;
            cnt_q     <= cnt_d;
            cout_q    <= cout_d;
        end
    end

    // Next-state, datapath update and handshake/serial outputs
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_sh_d  = sum_sh_q;
        cnt_d     = cnt_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_a_d = in_a;
                    shift_b_d = in_b;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_a     = shift_a_q[0];
                ser_b     = shift_b_q[0];
                // Sum bits arrive LSB first, so after W shifts bit 0 sits at index 0
                sum_sh_d  = {ser_sum, sum_sh_q[W-1:1]};
                shift_a_d = {1'b0, shift_a_q[W-1:1]};
                shift_b_d = {1'b0, shift_b_q[W-1:1]};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // With 0+0 driven the adder's sum equals its carry, and its next carry is 0
                cout_d  = ser_sum;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_sum  = sum_sh_q;
    assign out_cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sequencer
// Description : Self-checking bench for serial_add_sequencer with a
//               behavioural 1-bit serial adder and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         ser_a;
    logic         ser_b;
    logic         ser_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;

    logic         carry_q;
    logic [W:0]   sb[$];
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    int           n_cmp = 0;
    int           n_err = 0;

    serial_add_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_a     (ser_a),
        .ser_b     (ser_b),
        .ser_sum   (ser_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial adder: combinational sum, carry register with sync active-high reset (~rst)
    assign ser_sum = ser_a ^ ser_b ^ carry_q;
    always @(posedge clk) begin
        if (!rst) carry_q <= 1'b0;
        else      carry_q <= (ser_a & ser_b) | (ser_a & carry_q) | (ser_b & carry_q);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {in_ready, out_valid, ser_a, ser_b, out_cout, out_sum},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {W{1'b0}}});
    endtask

    // Present an operand pair, wait for acceptance, record the expected result
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        cur_a = a;
        cur_b = b;
        sb.push_back({1'b0, a} + {1'b0, b});
        step();
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
    endtask

    // Follow the word through SHIFT/FLUSH, then collect the result under backpressure
    task automatic receive(input int low_cycles, input bit rnd);
        int           n;
        int           k;
        bit           r;
        logic [W-1:0] sa;
        logic [W-1:0] sbits;
        logic [W-1:0] held;
        logic         held_c;
        logic [W:0]   exp;
        n     = 0;
        sa    = '0;
        sbits = '0;
        while (!out_valid && n < 100) begin
            if (n < W) begin
                sa[n]    = ser_a;
                sbits[n] = ser_b;
            end else begin
                check("flush_ser_zero", {30'd0, ser_a, ser_b}, 32'd0);
            end
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            n++;
        end
        if (!out_valid) begin
            check("result_timeout", {31'd0, out_valid}, 32'd1);
            return;
        end
        check("latency", n, W + 1);
        check("ser_a_bits", sa, cur_a);
        check("ser_b_bits", sbits, cur_b);
        held   = out_sum;
        held_c = out_cout;
        k      = 0;
        while (k < 1000) begin
            r = rnd ? 1'($urandom_range(0, 1)) : (k >= low_cycles);
            check("done_hold", {out_valid, in_ready, ser_a, ser_b, out_cout, out_sum},
                  {1'b1, 1'b0, 1'b0, 1'b0, held_c, held});
            if (r) begin
                out_ready = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("result", {out_cout, out_sum}, exp);
                end
                step();
                out_ready = 1'b0;
                check("after_handshake", {30'd0, out_valid, in_ready}, 32'd1);
                break;
            end
            out_ready = 1'b0;
            step();
            k++;
        end
        if (k >= 1000) check("release_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        cur_a     = '0;
        cur_b     = '0;
        step();
        step();
        check_reset_outputs("reset_state");
        rst = 1'b1;
        step();
        check_reset_outputs("idle_after_reset");

        // Directed sums including carry-out and flush-clears-carry cases
        send(8'h01, 8'h01); receive(0, 1'b0);
        send(8'hFF, 8'h01); receive(0, 1'b0);
        send(8'h00, 8'h00); receive(0, 1'b0);
        send(8'hA5, 8'h5A); receive(0, 1'b0);
        send(8'h80, 8'h80); receive(0, 1'b0);

        // Backpressure: five DONE cycles with out_ready low
        send(8'h3C, 8'hC7); receive(5, 1'b0);

        // Reset pulse while bit 3 is on the serial lines
        send(8'h77, 8'h99);
        step();
        step();
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("reset_mid_async");
        step();
        step();
        check_reset_outputs("reset_mid_held");
        rst = 1'b1;
        void'(sb.pop_back());
        step();
        check_reset_outputs("idle_after_abort");
        send(8'h12, 8'h34); receive(0, 1'b0);

        // Random operands with random input gaps and random out_ready
        for (int i = 0; i < 500; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                out_ready = 1'($urandom_range(0, 1));
                step();
            end
            out_ready = 1'b0;
            send(W'($urandom), W'($urandom));
            receive(0, 1'b1);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
